sseg_arbiter: RTL
=================

# sseg_arbiter

Arbitrates the four-digit seven-segment display among three requesters: the floppy track (default), the harddisk controller and the control block. It latches each request's 16-bit value and selects one source by fixed priority, holding each shown value for a minimum time before lower-priority traffic may replace it. It sits between the IO requesters and the `sseg_decode` instances, and drives the four nibbles they decode.

## Interface
- `TICK_DIV`, 7094: `clk7_en` cycles per 1 ms tick; counter width 13 bits.
- `HOLD_MS`, 500: minimum display time in ms; counter width 10 bits.
- `BLINK_MS`, 250: blink half-period in ms; only used with the blink macro.
- `clk` in 1: 28.37516 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk7_en` in 1: 7 MHz enable. All state advances only when it is high.
- `trk` in 8: live floppy track number (source 0, always valid).
- `hd_req` in 1: harddisk request (source 1). Level; held until `hd_ack`.
- `hd_val` in 16: harddisk value. Stable while `hd_req` is high.
- `cb_req` in 1: control-block request (source 2). Level; held until `cb_ack`.
- `cb_val` in 16: control-block value.
- `cb_alert` in 1: flags a control-block value for blink. Sampled with `cb_val`.
- `hd_ack` out 1: one enable-cycle pulse when the harddisk value has been latched.
- `cb_ack` out 1: one enable-cycle pulse when the control-block value has been latched.
- `disp_val` out 16: value to display; nibble n drives digit n.
- `disp_src` out 2: source currently shown: 0 = floppy, 1 = harddisk, 2 = control block.
- `disp_blank` out 1: blank all digits.
- `disp_upd` out 1: one enable-cycle pulse whenever `disp_val` or `disp_src` changes.

## Operation
- Latch rule: on an enable cycle with `x_req` high and `x_ack` low:
  - latch `x_val` into `val_x` and set `pend_x`;
  - pulse `x_ack` on the next enable cycle.
- A requester must drop `req` after `ack`. If `req` is still high on the enable cycle after `ack`, that is a new request.
- Priority is control block > harddisk > floppy.
- FSM states: IDLE, SHOW, WAIT.
- IDLE:
  - `disp_src` = 0 and `disp_val` = {8'h00, trk}, tracking `trk` live with one enable cycle of register delay.
  - Any pending request → SHOW with the highest pending source.
- SHOW:
  - Entry: load the hold counter with `HOLD_MS`, clear that source's `pend`, update `disp_val`/`disp_src`, pulse `disp_upd`.
  - New latch from the same source: update the value and restart the hold.
  - New latch from a higher-priority source: preempt immediately (re-enter SHOW for that source).
  - New latch from a lower-priority source: stays pending.
  - Hold counter reaches 0 → WAIT.
- WAIT (one enable cycle):
  - A pending source exists → SHOW with the highest pending source.
  - Otherwise → IDLE, pulse `disp_upd`.
- Simultaneous `hd_req` and `cb_req`: both are latched and acked in the same cycle. The control block is shown first; the harddisk follows after the hold expires.
- The ms prescaler free-runs 0..`TICK_DIV`-1. The hold counter decrements on a tick only, so the actual hold time is within (`HOLD_MS`-1, `HOLD_MS`] ms.

## Timing
- Reset values:
  - outputs: `disp_val` = 0, `disp_src` = 0, `disp_blank` = 0, all acks and `disp_upd` = 0;
  - internal: FSM = IDLE, pendings clear, counters 0.
- Latency from `req` sampled to `ack`: 1 enable cycle.
- Latency from `req` sampled to `disp_val` updated: 2 enable cycles, when the request wins arbitration.
- All outputs are registered and change only on enable cycles.
- `rst_n` deasserting mid-hold aborts the shown value. The first cycles after reset are IDLE showing `trk`.

## Configuration
- `SSEG_ARB_BLINK_EN` defined:
  - while in SHOW with source 2 and the latched `cb_alert` = 1, `disp_blank` toggles every `BLINK_MS` ticks, starting at 0 on entry;
  - `disp_blank` is forced to 0 in all other cases.
- `SSEG_ARB_BLINK_EN` not defined: `disp_blank` is tied to 0, and the blink counter and `cb_alert` register are not built.

## Test plan
- Reset with `trk` = 8'h2A, then release → `disp_src` = 0 and `disp_val` = 16'h002A within 1 enable cycle; all acks low.
- `hd_req` with `hd_val` = 16'h1234, using `TICK_DIV` = 4 and `HOLD_MS` = 3 → `hd_ack` pulses once; `disp_val` = 16'h1234 and `disp_src` = 1 for 12 ±4 enable cycles; then back to `trk`, with `disp_upd` on both edges.
- During the harddisk hold, `cb_req` with 16'hBEEF → immediate preemption: `disp_src` = 2 with a fresh hold. Return to IDLE, not to the harddisk.
- `hd_req` and `cb_req` asserted in the same cycle → both acked; the control-block value is shown, then the harddisk value, then the track.
- Same-source refresh: a second `hd_req` with 16'h0001 during the hold → value updates and the hold restarts.
- With `SSEG_ARB_BLINK_EN` and `cb_alert` = 1 (`BLINK_MS` = 1) → `disp_blank` toggles every 4 enable cycles while shown. With the macro undefined, `disp_blank` stays 0.

Source files
------------

// File: rtl/sseg_arbiter.sv
// sseg_arbiter: fixed-priority (control block > harddisk > floppy) seven-segment display arbiter with minimum hold time
// ports: clk, rst_n (async, active low), clk7_en (state advances only when high), trk (live floppy track),
//        hd_req/hd_val/hd_ack and cb_req/cb_val/cb_alert/cb_ack (level request, one-cycle ack),
//        disp_val/disp_src/disp_blank/disp_upd (registered display outputs)
// SSEG_ARB_BLINK_EN: when defined, alert-flagged control-block values blink via disp_blank; otherwise disp_blank is 0
module sseg_arbiter #(
  parameter int TICK_DIV = 7094,
  parameter int HOLD_MS  = 500,
  parameter int BLINK_MS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk7_en,
  input  logic [7:0]  trk,
  input  logic        hd_req,
  input  logic [15:0] hd_val,
  input  logic        cb_req,
  input  logic [15:0] cb_val,
  input  logic        cb_alert,
  output logic        hd_ack,
  output logic        cb_ack,
  output logic [15:0] disp_val,
  output logic [1:0]  disp_src,
  output logic        disp_blank,
  output logic        disp_upd
);
  localparam logic [12:0] TICK_LAST  = 13'(TICK_DIV - 1);
  localparam logic [9:0]  HOLD_INIT  = 10'(HOLD_MS);
  localparam logic [9:0]  BLINK_LAST = 10'(BLINK_MS - 1);
  typedef enum logic [1:0] {IDLE, SHOW, WAIT} state_t;
  state_t      state;
  logic [12:0] presc;
  logic [9:0]  hold;
  logic [15:0] val_hd, val_cb, idle_val;
  logic        pend_hd, pend_cb, hd_lat, cb_lat, tick, go;
  logic [1:0]  top;
  // in SHOW only a pending source of equal or higher priority may take over (refresh or preempt)
  always_comb begin
    hd_lat   = hd_req & ~hd_ack;
    cb_lat   = cb_req & ~cb_ack;
    tick     = presc == TICK_LAST;
    top      = pend_cb ? 2'd2 : pend_hd ? 2'd1 : 2'd0;
    go       = (pend_hd | pend_cb) & (state != SHOW | top >= disp_src);
    idle_val = {8'h00, trk};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      hold     <= '0;
      val_hd   <= '0;
      val_cb   <= '0;
      pend_hd  <= 1'b0;
      pend_cb  <= 1'b0;
      hd_ack   <= 1'b0;
      cb_ack   <= 1'b0;
      disp_val <= '0;
      disp_src <= '0;
      disp_upd <= 1'b0;
    end else if (clk7_en) begin
      presc    <= tick ? '0 : presc + 13'd1;
      hd_ack   <= hd_lat;
      cb_ack   <= cb_lat;
      if (hd_lat) val_hd <= hd_val;
      if (cb_lat) val_cb <= cb_val;
      // a fresh latch wins over the clear of the same source's pend on entry
      pend_hd  <= hd_lat | (pend_hd & ~(go & top == 2'd1));
      pend_cb  <= cb_lat | (pend_cb & ~(go & top == 2'd2));
      disp_upd <= 1'b0;
      if (go) begin
        state    <= SHOW;
        disp_src <= top;
        disp_val <= top == 2'd2 ? val_cb : val_hd;
        disp_upd <= 1'b1;
        hold     <= HOLD_INIT;
      end else if (state == SHOW) begin
        if (tick) begin
          hold <= hold - 10'd1;
          if (hold <= 10'd1) state <= WAIT;
        end
      end else begin
        state    <= IDLE;
        disp_src <= 2'd0;
        disp_val <= idle_val;
        disp_upd <= state == WAIT | idle_val != disp_val;
      end
    end
  end
`ifdef SSEG_ARB_BLINK_EN
  logic       alert_cb, alert_shown;
  logic [9:0] blink_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_cb    <= 1'b0;
      alert_shown <= 1'b0;
      blink_cnt   <= '0;
      disp_blank  <= 1'b0;
    end else if (clk7_en) begin
      if (cb_lat) alert_cb <= cb_alert;
      if (go) begin
        alert_shown <= top == 2'd2 & alert_cb;
        blink_cnt   <= '0;
        disp_blank  <= 1'b0;
      end else if (state == SHOW & alert_shown) begin
        if (tick) begin
          blink_cnt <= blink_cnt == BLINK_LAST ? '0 : blink_cnt + 10'd1;
          if (blink_cnt == BLINK_LAST) disp_blank <= ~disp_blank;
        end
      end else begin
        disp_blank <= 1'b0;
      end
    end
  end
`else
  logic unused_blink;
  assign disp_blank   = 1'b0;
  assign unused_blink = cb_alert ^ BLINK_LAST[0];
`endif
endmodule
